// File: rtl/cache_ring_node.sv
// rtl/cache_ring_node.sv - ring transport stage: hold slot, forward/retire, request inject, line lock
// Message layout, MSB first: {read, inval, reply, ttl, tag, index, data}.
module cache_ring_node #(
    parameter int NODES   = 4,
    parameter int TAG_W   = 8,
    parameter int INDEX_W = 4,
    parameter int DATA_W  = 32,
    localparam int TTL_W  = (NODES > 2) ? $clog2(NODES) : 1,
    localparam int REQ_W  = 3 + TTL_W + TAG_W + INDEX_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic [REQ_W-1:0]   in_data,
    input  logic               in_data_valid,
    input  logic               in_data_ready,
    output logic [REQ_W-1:0]   in_hold,
    output logic               in_hold_valid,
    output logic               last_hop,

    output logic [REQ_W-1:0]   out_data,
    output logic               out_data_valid,
    input  logic               out_data_ready,
    output logic               out_stall,
    output logic               may_send,

    input  logic               send,
    input  logic               send_read,
    input  logic               send_inval,
    input  logic               set_reply,
    input  logic [TAG_W-1:0]   core_tag,
    input  logic [INDEX_W-1:0] core_index,
    input  logic [DATA_W-1:0]  data_rd,

    input  logic               lock_line,
    input  logic               unlock_line,
    output logic               locked
);

    localparam int IDX_LSB   = DATA_W;
    localparam int TAG_LSB   = IDX_LSB + INDEX_W;
    localparam int TTL_LSB   = TAG_LSB + TAG_W;
    localparam int REPLY_BIT = TTL_LSB + TTL_W;

    localparam logic [TTL_W-1:0] TTL_INIT = TTL_W'(NODES - 1);

    logic [REQ_W-1:0] hold_q;
    logic             hold_v;
    logic [REQ_W-1:0] out_q;
    logic             out_v;
    logic             locked_q;

    logic [TTL_W-1:0] hold_ttl;
    logic             consume;
    logic             forward;
    logic             load_hold;
    logic             load_out;
    logic [REQ_W-1:0] fwd_req;
    logic [REQ_W-1:0] inj_req;
    logic [REQ_W-1:0] next_out;

    assign hold_ttl  = hold_q[TTL_LSB +: TTL_W];
    assign last_hop  = (hold_ttl == '0);
    assign consume   = hold_v && in_data_ready;
    // ttl==0 messages are retired here, so the decrement below never wraps
    assign forward   = consume && !last_hop;
    assign load_hold = in_data_valid && in_data_ready;
    assign load_out  = forward || send;

    always_comb begin
        fwd_req = hold_q;
        fwd_req[TTL_LSB +: TTL_W] = hold_ttl - TTL_W'(1);
        if (set_reply) begin
            fwd_req[REPLY_BIT]     = 1'b1;
            fwd_req[DATA_W-1:0]    = data_rd;
        end
    end

    assign inj_req  = {send_read, send_inval, 1'b0, TTL_INIT, core_tag, core_index, data_rd};
    assign next_out = forward ? fwd_req : inj_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            hold_v <= 1'b0;
        end else if (load_hold) begin
            hold_q <= in_data;
            hold_v <= 1'b1;
        end else if (consume) begin
            hold_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else if (load_out) begin
            out_q <= next_out;
            out_v <= 1'b1;
        end else if (out_v && out_data_ready) begin
            out_v <= 1'b0;
        end
    end

    // unlock has priority over a simultaneous lock request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
        end else if (unlock_line) begin
            locked_q <= 1'b0;
        end else if (lock_line && send) begin
            locked_q <= 1'b1;
        end
    end

    assign in_hold        = hold_q;
    assign in_hold_valid  = hold_v;
    assign out_data       = out_q;
    assign out_data_valid = out_v;
    assign out_stall      = out_v;
    assign may_send       = !out_v || out_data_ready;
    assign locked         = locked_q;

endmodule

// File: doc/cache_ring_node.md
# cache_ring_node

Ring transport stage between the inter-cache token ring and `cache_control`. It registers the incoming ring message into a hold slot and exposes it to the controller as `in_hold`. It forwards or retires each held message after the controller consumes it. It also injects the controller's own read/invalidate requests into a single-entry output register toward the next node.

## Interface

Parameters:
- `NODES`, 4: caches on the ring; a new request starts with `ttl = NODES-1`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in `ring_req`: message from the previous node. Fields: `read`, `inval`, `reply`, `ttl`, `tag`, `index`, `data`.
- `in_data_valid` in 1: previous node presents `in_data`.
- `in_data_ready` in 1: from `cache_control`. Allows loading the hold slot, and consumes the current hold if valid.
- `in_hold` out `ring_req`: held message.
- `in_hold_valid` out 1: hold slot occupied.
- `last_hop` out 1: `in_hold.ttl == 0`.
- `out_data` out `ring_req`: message to the next node.
- `out_data_valid` out 1: output register occupied.
- `out_data_ready` in 1: next node accepts `out_data`.
- `out_stall` out 1: `out_data_valid`.
- `may_send` out 1: `!out_data_valid || out_data_ready`.
- `send`, `send_read`, `send_inval` in 1 each: inject a new request.
- `set_reply` in 1: mark the message being forwarded as a reply carrying `data_rd`.
- `core_tag` in `addr_tag`, `core_index` in `addr_index`, `data_rd` in `line`: payload sources.
- `lock_line`, `unlock_line` in 1: set and clear the lock.
- `locked` out 1: this node owns an outstanding core transaction.

## Operation

- **consume** = `in_hold_valid && in_data_ready`.
  - If `!last_hop`, the message is forwarded: copied to the output register with `ttl-1`.
    - If `set_reply` is high in that cycle, `reply` is forced to 1 and `data` is replaced by `data_rd`.
    - `read`, `inval`, `tag` and `index` are always copied unchanged.
  - If `last_hop`, the message is retired (dropped).
- **Hold load**:
  - `in_data_valid && in_data_ready` → `in_hold <= in_data`, `in_hold_valid <= 1`. Consume and load may occur in the same cycle.
  - Otherwise, on consume → `in_hold_valid <= 0`.
  - `in_hold` contents are unchanged when not loading.
- **Inject**: `send` loads the output register with:
  - `read = send_read`, `inval = send_inval`, `reply = 0`, `ttl = NODES-1`;
  - `tag = core_tag`, `index = core_index`, `data = data_rd`.
- **Output register**:
  - Loaded by either a forward or an inject.
  - Cleared when `out_data_valid && out_data_ready` and no new load occurs in that cycle.
  - Load while the register is full and not draining is illegal. So is a forward and an inject in the same cycle. Both are covered by bench assertions; the controller guarantees them via `out_stall`/`may_send`.
- **Lock**:
  - `locked` sets on `lock_line && send`.
  - It clears on `unlock_line`, which wins if both are asserted.
- **Reset values**: `in_hold_valid=0`, `out_data_valid=0`, `locked=0`, `in_hold` and `out_data` all-zero. Consequently `last_hop=1`, `may_send=1`, `out_stall=0`.

## Timing

- Hold-to-forward latency is 1 cycle: a message consumed in cycle N is visible on `out_data_valid` in cycle N+1.
- Ring throughput: when the controller consumes the hold every cycle and the downstream node is always ready, one message per cycle flows through the node.
- Output back-pressure:
  - `out_data` and `out_data_valid` are held stable while `!out_data_ready`.
  - `may_send` is combinational from `out_data_ready`, so a drain and a new load in the same cycle is a legal back-to-back transfer.
- Behaviour at the boundaries:
  - `ttl` never underflows; `ttl == 0` messages are never forwarded.
  - An asynchronous reset mid-transfer discards both held and output messages immediately.

## Test plan

- **Reset**: assert `rst_n=0` mid-traffic → `in_hold_valid=0`, `out_data_valid=0`, `locked=0`, `may_send=1` asynchronously.
- **Forward**:
  - Stimulus: present `read=1, ttl=2, tag=0x12, index=5`; controller consumes with `set_reply=0`.
  - Required: next cycle `out_data` has `ttl=1`, `reply=0`, identical `tag`/`index`/`data`.
- **Reply insertion**:
  - Stimulus: hold `read=1, ttl=1`; consume with `set_reply=1` and `data_rd=0xA5..A5`.
  - Required: `out_data.reply=1`, `data=0xA5..A5`, `ttl=0`.
- **Retire**:
  - Stimulus: hold `ttl=0` (`last_hop=1`), then consume.
  - Required: `in_hold_valid` drops next cycle and `out_data_valid` stays 0.
- **Inject under back-pressure**:
  - Stimulus: `send` with `send_read=1`, `send_inval=1`, `core_tag=0x3`, `core_index=7`, `NODES=4`; hold `out_data_ready=0` for 3 cycles.
  - Required: `out_data` is stable with `ttl=3`, `read=1`, `inval=1`; `may_send=0` until the cycle `out_data_ready=1`.
- **Lock and back-to-back transfer**:
  - Stimulus: `lock_line`+`send` → `locked=1`. Then hold load and consume in the same cycle.
  - Required: the new message is held with `in_hold_valid` staying 1, and the old message is forwarded.
  - Then: `unlock_line` → `locked=0` next cycle.
